// File: rtl/psk_symbol_mapper_pkg.sv
// Shared encodings for the PSK symbol mapper and its constellation helper.
package psk_pkg;

    // Modulation mode encodings for configuration/status fields.
    localparam logic [1:0] MODE_BPSK = 2'd0;
    localparam logic [1:0] MODE_QPSK = 2'd1;
    localparam logic [1:0] MODE_MIX  = 2'd2;

    // Symbol-hold state machine encoding.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int DEFAULT_IQ_W = 12;
    localparam int DEFAULT_AMP  = 1447;

    // BPSK replicates the I bit onto both axes; QPSK uses both raw bits.
    function automatic logic [1:0] select_bits(input logic [1:0] raw, input logic is_bpsk);
        logic [1:0] sel;
        if (is_bpsk) begin
            sel = {raw[1], raw[1]};
        end else begin
            sel = raw;
        end
        return sel;
    endfunction

endpackage

// File: rtl/psk_const_map.sv
// Gray constellation mapper: {e, is_bpsk} -> signed {I, Q}. Purely combinational
// so the receiver-side decision reference can reuse it unchanged.
module psk_const_map
    import psk_pkg::*;
#(
    parameter int IQ_W = DEFAULT_IQ_W,
    parameter int AMP  = DEFAULT_AMP
) (
    input  logic [1:0]             e,
    input  logic                   is_bpsk,
    output logic signed [IQ_W-1:0] i_out,
    output logic signed [IQ_W-1:0] q_out
);

    localparam logic signed [IQ_W-1:0] POS_AMP = IQ_W'(AMP);
    localparam logic signed [IQ_W-1:0] NEG_AMP = -POS_AMP;

    // Bit 1 selects the I sign, bit 0 the Q sign; BPSK keeps Q on the axis.
    always_comb begin
        i_out = POS_AMP;
        q_out = {IQ_W{1'b0}};
        if (e[1]) begin
            i_out = NEG_AMP;
        end else begin
            i_out = POS_AMP;
        end
        if (is_bpsk) begin
            q_out = {IQ_W{1'b0}};
        end else if (e[0]) begin
            q_out = NEG_AMP;
        end else begin
            q_out = POS_AMP;
        end
    end

endmodule

// File: rtl/psk_symbol_mapper.sv
// Takes one AXIS beat per symbol period, maps it to a BPSK/QPSK symbol and
// holds that symbol on I/Q for SPS clocks. Flags starvation inside a burst.
module psk_symbol_mapper
    import psk_pkg::*;
#(
    parameter int BYTES   = 1,
    parameter int IQ_W    = DEFAULT_IQ_W,
    parameter int SPS     = 8,
    parameter int AMP     = DEFAULT_AMP,
    parameter int DIFF_EN = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BYTES*8-1:0]     data_tdata,
    input  logic                   data_tvalid,
    output logic                   data_tready,
    input  logic                   data_tlast,
    input  logic                   data_tuser,
    output logic signed [IQ_W-1:0] iq_i,
    output logic signed [IQ_W-1:0] iq_q,
    output logic                   iq_valid,
    output logic                   sym_strobe,
    output logic                   sym_is_bpsk,
    output logic                   sym_last,
    output logic                   underrun,
    input  logic                   clr_underrun
);

    localparam int              CNT_W    = (SPS > 2) ? $clog2(SPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             prev_q, prev_d;
    logic signed [IQ_W-1:0] iq_i_q, iq_i_d;
    logic signed [IQ_W-1:0] iq_q_q, iq_q_d;
    logic                   iq_valid_q, iq_valid_d;
    logic                   strobe_q, strobe_d;
    logic                   bpsk_q, bpsk_d;
    logic                   last_q, last_d;
    logic                   underrun_q, underrun_d;

    logic                   tready_s;
    logic                   accept_s;
    logic [1:0]             b_s;
    logic [1:0]             prev_base_s;
    logic [1:0]             e_s;
    logic signed [IQ_W-1:0] map_i_s;
    logic signed [IQ_W-1:0] map_q_s;
    logic                   unused_tdata_s;

    assign unused_tdata_s = ^data_tdata[BYTES*8-1:2];

    // Ready comes only from registered state so the source sees no valid->ready path.
    always_comb begin
        tready_s = 1'b0;
        if (state_q == IDLE) begin
            tready_s = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            tready_s = 1'b1;
        end else begin
            tready_s = 1'b0;
        end
    end

    assign accept_s = data_tvalid && tready_s;

    // Bit selection and optional differential encoding; a burst restart from IDLE
    // encodes against zero instead of the stale history.
    always_comb begin
        b_s = select_bits(data_tdata[1:0], data_tuser);
        if (state_q == IDLE) begin
            prev_base_s = 2'b00;
        end else begin
            prev_base_s = prev_q;
        end
        if (DIFF_EN != 0) begin
            e_s = b_s ^ prev_base_s;
        end else begin
            e_s = b_s;
        end
    end

    psk_const_map #(
        .IQ_W (IQ_W),
        .AMP  (AMP)
    ) u_const_map (
        .e       (e_s),
        .is_bpsk (data_tuser),
        .i_out   (map_i_s),
        .q_out   (map_q_s)
    );

    // Next-state logic: load on accept, count while holding, drop to idle when starved.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        iq_i_d     = iq_i_q;
        iq_q_d     = iq_q_q;
        iq_valid_d = iq_valid_q;
        strobe_d   = 1'b0;
        bpsk_d     = bpsk_q;
        last_d     = last_q;
        if (clr_underrun) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end

        if (accept_s) begin
            state_d    = HOLD;
            cnt_d      = {CNT_W{1'b0}};
            iq_i_d     = map_i_s;
            iq_q_d     = map_q_s;
            iq_valid_d = 1'b1;
            strobe_d   = 1'b1;
            bpsk_d     = data_tuser;
            last_d     = data_tlast;
            if (data_tuser) begin
                prev_d = {e_s[1], e_s[1]};
            end else begin
                prev_d = e_s;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                HOLD: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d    = IDLE;
                        cnt_d      = {CNT_W{1'b0}};
                        iq_i_d     = {IQ_W{1'b0}};
                        iq_q_d     = {IQ_W{1'b0}};
                        iq_valid_d = 1'b0;
                        if (!last_q) begin
                            underrun_d = 1'b1;
                        end else begin
                            underrun_d = underrun_d;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d    = IDLE;
                    cnt_d      = {CNT_W{1'b0}};
                    iq_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            prev_q     <= 2'b00;
            iq_i_q     <= {IQ_W{1'b0}};
            iq_q_q     <= {IQ_W{1'b0}};
            iq_valid_q <= 1'b0;
            strobe_q   <= 1'b0;
            bpsk_q     <= 1'b0;
            last_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            iq_i_q     <= iq_i_d;
            iq_q_q     <= iq_q_d;
            iq_valid_q <= iq_valid_d;
            strobe_q   <= strobe_d;
            bpsk_q     <= bpsk_d;
            last_q     <= last_d;
            underrun_q <= underrun_d;
        end
    end

    assign data_tready = tready_s;
    assign iq_i        = iq_i_q;
    assign iq_q        = iq_q_q;
    assign iq_valid    = iq_valid_q;
    assign sym_strobe  = strobe_q;
    assign sym_is_bpsk = bpsk_q;
    assign sym_last    = last_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_psk_symbol_mapper.sv
// Scoreboard bench: one plain and one differential mapper share the same stimulus.
module tb_psk_symbol_mapper;

    localparam int BYTES = 1;
    localparam int IQ_W  = 12;
    localparam int SPS   = 8;
    localparam int AMP   = 1447;

    typedef struct {
        int i;
        int q;
        bit bpsk;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [BYTES*8-1:0] data_tdata;
    logic data_tvalid, data_tlast, data_tuser, clr_underrun;

    logic                   tready0, valid0, strobe0, bpsk0, last0, under0;
    logic signed [IQ_W-1:0] iq_i0, iq_q0;
    logic                   tready1, valid1, strobe1, bpsk1, last1, under1;
    logic signed [IQ_W-1:0] iq_i1, iq_q1;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t cur [2];
    int   hold [2];
    logic [1:0] prev1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psk_symbol_mapper #(.BYTES(BYTES), .IQ_W(IQ_W), .SPS(SPS), .AMP(AMP), .DIFF_EN(0)) dut0 (
        .clk(clk), .rst(rst), .data_tdata(data_tdata), .data_tvalid(data_tvalid),
        .data_tready(tready0), .data_tlast(data_tlast), .data_tuser(data_tuser),
        .iq_i(iq_i0), .iq_q(iq_q0), .iq_valid(valid0), .sym_strobe(strobe0),
        .sym_is_bpsk(bpsk0), .sym_last(last0), .underrun(under0), .clr_underrun(clr_underrun)
    );

    psk_symbol_mapper #(.BYTES(BYTES), .IQ_W(IQ_W), .SPS(SPS), .AMP(AMP), .DIFF_EN(1)) dut1 (
        .clk(clk), .rst(rst), .data_tdata(data_tdata), .data_tvalid(data_tvalid),
        .data_tready(tready1), .data_tlast(data_tlast), .data_tuser(data_tuser),
        .iq_i(iq_i1), .iq_q(iq_q1), .iq_valid(valid1), .sym_strobe(strobe1),
        .sym_is_bpsk(bpsk1), .sym_last(last1), .underrun(under1), .clr_underrun(clr_underrun)
    );

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int amp_of(input logic bit_v);
        return bit_v ? -AMP : AMP;
    endfunction

    // Expected symbols for both instances, computed from the stimulus alone.
    task automatic push_beat(input logic [1:0] d, input logic bpsk, input logic last,
                             input logic restart);
        logic [1:0] b;
        logic [1:0] e1;
        exp_t x;
        b      = bpsk ? {d[1], d[1]} : d;
        x.i    = amp_of(b[1]);
        x.q    = bpsk ? 0 : amp_of(b[0]);
        x.bpsk = bpsk;
        x.last = last;
        sb0.push_back(x);
        if (restart) prev1 = 2'b00;
        e1    = b ^ prev1;
        prev1 = bpsk ? {e1[1], e1[1]} : e1;
        x.i   = amp_of(e1[1]);
        x.q   = bpsk ? 0 : amp_of(e1[0]);
        sb1.push_back(x);
    endtask

    // Offer one beat and keep it valid until the DUT takes it (bounded wait).
    task automatic send_beat(input logic [1:0] d, input logic bpsk, input logic last,
                             input logic restart);
        logic [5:0] upper;
        bit acc;
        push_beat(d, bpsk, last, restart);
        upper       = 6'($urandom_range(0, 63));
        data_tdata  = {upper, d};
        data_tuser  = bpsk;
        data_tlast  = last;
        data_tvalid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 4 * SPS && !acc; n++) begin
            @(negedge clk);
            acc = tready0;
            @(posedge clk);
            #1;
        end
        check_eq("accept_timeout", int'(acc), 1);
    endtask

    task automatic idle_wait();
        data_tvalid = 1'b0;
        repeat (SPS + 3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic mon(input int idx, input logic strobe, input logic valid, input int i,
                       input int q, input logic bpsk, input logic last, input logic ready);
        exp_t x;
        int   sz;
        bit   exp_rdy;
        if (strobe) begin
            check_eq($sformatf("strobe_valid%0d", idx), int'(valid), 1);
            sz = (idx == 0) ? sb0.size() : sb1.size();
            check_eq($sformatf("sb%0d_nonempty", idx), int'(sz > 0), 1);
            if (sz > 0) begin
                x = (idx == 0) ? sb0.pop_front() : sb1.pop_front();
                cur[idx]  = x;
                hold[idx] = 0;
            end
            check_eq($sformatf("sym%0d_i", idx), i, cur[idx].i);
            check_eq($sformatf("sym%0d_q", idx), q, cur[idx].q);
            check_eq($sformatf("sym%0d_bpsk", idx), int'(bpsk), int'(cur[idx].bpsk));
            check_eq($sformatf("sym%0d_last", idx), int'(last), int'(cur[idx].last));
        end else if (valid) begin
            hold[idx]++;
            check_eq($sformatf("hold%0d_len_ok", idx), int'(hold[idx] < SPS), 1);
            check_eq($sformatf("hold%0d_i", idx), i, cur[idx].i);
            check_eq($sformatf("hold%0d_q", idx), q, cur[idx].q);
        end else begin
            check_eq($sformatf("idle%0d_i", idx), i, 0);
            check_eq($sformatf("idle%0d_q", idx), q, 0);
        end
        exp_rdy = !valid || (hold[idx] == SPS - 1);
        check_eq($sformatf("tready%0d", idx), int'(ready), int'(exp_rdy));
    endtask

    // Output monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            mon(0, strobe0, valid0, iq_i0, iq_q0, bpsk0, last0, tready0);
            mon(1, strobe1, valid1, iq_i1, iq_q1, bpsk1, last1, tready1);
        end
    end

    task automatic check_idle(input string tag);
        check_eq({tag, "_tready0"}, int'(tready0), 1);
        check_eq({tag, "_valid0"}, int'(valid0), 0);
        check_eq({tag, "_strobe0"}, int'(strobe0), 0);
        check_eq({tag, "_i0"}, int'(iq_i0), 0);
        check_eq({tag, "_q0"}, int'(iq_q0), 0);
        check_eq({tag, "_tready1"}, int'(tready1), 1);
        check_eq({tag, "_valid1"}, int'(valid1), 0);
        check_eq({tag, "_i1"}, int'(iq_i1), 0);
        check_eq({tag, "_q1"}, int'(iq_q1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        data_tdata   = '0;
        data_tvalid  = 1'b0;
        data_tlast   = 1'b0;
        data_tuser   = 1'b0;
        clr_underrun = 1'b0;
        prev1        = 2'b00;
        hold[0]      = 0;
        hold[1]      = 0;

        // Reset held for three clocks.
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check_eq("reset_under0", int'(under0), 0);
        check_eq("reset_under1", int'(under1), 0);
        check_eq("reset_bpsk0", int'(bpsk0), 0);
        check_eq("reset_last0", int'(last0), 0);
        rst = 1'b0;

        // QPSK burst 0,1,3,2 with continuous valid.
        send_beat(2'b00, 1'b0, 1'b0, 1'b1);
        send_beat(2'b01, 1'b0, 1'b0, 1'b0);
        send_beat(2'b11, 1'b0, 1'b0, 1'b0);
        send_beat(2'b10, 1'b0, 1'b1, 1'b0);
        idle_wait();
        check_idle("qpsk_end");
        check_eq("qpsk_under0", int'(under0), 0);
        check_eq("qpsk_under1", int'(under1), 0);

        // BPSK burst 10, 00.
        send_beat(2'b10, 1'b1, 1'b0, 1'b1);
        send_beat(2'b00, 1'b1, 1'b1, 1'b0);
        idle_wait();
        check_eq("bpsk_under0", int'(under0), 0);

        // Starvation inside a burst.
        send_beat(2'b11, 1'b0, 1'b0, 1'b1);
        send_beat(2'b01, 1'b0, 1'b0, 1'b0);
        data_tvalid = 1'b0;
        repeat (SPS) @(negedge clk);
        check_eq("starve_last_cycle_valid0", int'(valid0), 1);
        @(negedge clk);
        check_eq("starve_drop_valid0", int'(valid0), 0);
        check_eq("starve_drop_valid1", int'(valid1), 0);
        check_eq("starve_under0", int'(under0), 1);
        check_eq("starve_under1", int'(under1), 1);
        repeat (18) @(negedge clk);
        check_eq("starve_sticky0", int'(under0), 1);
        @(posedge clk);
        #1 clr_underrun = 1'b1;
        @(posedge clk);
        #1 clr_underrun = 1'b0;
        @(negedge clk);
        check_eq("clr_under0", int'(under0), 0);
        check_eq("clr_under1", int'(under1), 0);
        @(posedge clk);
        #1;

        // Differential stream 01,01,00.
        send_beat(2'b01, 1'b0, 1'b0, 1'b1);
        send_beat(2'b01, 1'b0, 1'b0, 1'b0);
        send_beat(2'b00, 1'b0, 1'b1, 1'b0);
        idle_wait();
        check_eq("diff_under1", int'(under1), 0);

        // Reset in the middle of a symbol (cnt==3) with a beat on offer.
        send_beat(2'b11, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst         = 1'b1;
        data_tdata  = 8'h01;
        data_tuser  = 1'b0;
        data_tlast  = 1'b1;
        data_tvalid = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        data_tvalid = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        @(posedge clk);
        #1;
        send_beat(2'b01, 1'b0, 1'b1, 1'b1);
        idle_wait();
        check_eq("midrst_under0", int'(under0), 0);

        check_eq("sb0_drained", sb0.size(), 0);
        check_eq("sb1_drained", sb1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psk_symbol_mapper.md
Name: psk_symbol_mapper

Overview:
- Sits directly downstream of the PN/test-data source.
- Consumes its AXIS beats (bit field in tdata[1:0], tuser = is_bpsk) and maps each beat to one BPSK or QPSK baseband symbol on signed I/Q.
- Holds each symbol for SPS clocks and feeds the pulse-shaping/DUC stage.
- Back-pressures the source so exactly one beat is taken per symbol period.

Parameters:
- BYTES, 1, AXIS tdata width in bytes; only tdata[1:0] is used.
- IQ_W, 12, signed width of the I/Q outputs.
- SPS, 8, clocks per symbol; legal range 2..256.
- AMP, 1447, constellation amplitude per axis; must satisfy 0 < AMP <= 2^(IQ_W-1)-1.
- DIFF_EN, 0, 1 enables per-bit differential encoding before mapping.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- data_tdata  in  BYTES*8  symbol bits; bit1 = I bit, bit0 = Q bit
- data_tvalid  in  1  AXIS valid
- data_tready  out  1  AXIS ready
- data_tlast  in  1  last symbol of the burst
- data_tuser  in  1  1 = BPSK beat, 0 = QPSK beat
- iq_i  out  IQ_W  signed in-phase sample
- iq_q  out  IQ_W  signed quadrature sample
- iq_valid  out  1  I/Q carry a symbol (0 while idle)
- sym_strobe  out  1  first clock of each symbol period
- sym_is_bpsk  out  1  modulation of the current symbol
- sym_last  out  1  current symbol came from a tlast beat
- underrun  out  1  sticky: source starved mid-burst
- clr_underrun  in  1  clears underrun

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, cnt=0, diff register=2'b00. All outputs 0 except data_tready=1.
- Reset mid-symbol aborts the symbol; the next cycle shows idle outputs.
- States:
  - IDLE: no symbol being held.
  - HOLD: symbol being held; cnt counts 0..SPS-1.
- data_tready = (state==IDLE) || (state==HOLD && cnt==SPS-1). It is decoded from registered state only, with no combinational path from data_tvalid.
- Accept = data_tvalid && data_tready. On accept:
  - state <= HOLD, cnt <= 0.
  - I/Q, sym_is_bpsk, sym_last are registered from the beat.
  - sym_strobe=1 and iq_valid=1 the next cycle.
  - Latency: beat accepted at edge N gives its symbol on the outputs from N+1 through N+SPS.
- HOLD with cnt<SPS-1: cnt++; outputs held; sym_strobe=0.
- HOLD with cnt==SPS-1 and no accept:
  - state <= IDLE; iq_i, iq_q, iq_valid <= 0.
  - If sym_last==0, set underrun (starved inside a burst).
  - If sym_last==1, this is a normal burst end; no flag.
- Back-to-back accepts give a continuous symbol stream with no gap cycles. sym_strobe pulses every SPS clocks.
- Bit selection:
  - BPSK: b = {tdata[1], tdata[1]}.
  - QPSK: b = tdata[1:0].
- Differential encoding (DIFF_EN=1):
  - e = b XOR prev; prev <= e on accept.
  - For BPSK, both bits of prev track e[1].
  - prev is cleared by rst, and by an accept that follows IDLE (burst restart).
  - With DIFF_EN=0, e = b.
- Mapping (Gray): iq_i = e[1] ? -AMP : +AMP.
- BPSK: iq_q = 0.
- QPSK: iq_q = e[0] ? -AMP : +AMP.
- Negation is two's complement at IQ_W bits; AMP never overflows.
- Mode may change on any beat boundary; mixed BPSK/QPSK streams are legal. tuser is sampled per beat only.
- Upper tdata bits [BYTES*8-1:2] are ignored.
- clr_underrun has priority below a same-cycle set: if set and clear coincide, underrun=1.
- data_tvalid dropping while tready=0 is ignored; no beat is lost or duplicated.

Decomposition:
- Shared package (psk_pkg) holds:
  - MODE_BPSK / MODE_QPSK / MODE_MIX encodings
  - state encoding IDLE/HOLD
  - default IQ_W and AMP
- One natural sub-module: psk_const_map (combinational {e, is_bpsk} -> {I, Q}). It is reusable by the receiver-side decision reference.
- Counter and FSM stay in the top.

Test Plan:
- Reset, then hold rst=1 for 3 clocks → tready=1, iq_valid=0, iq_i=iq_q=0, underrun=0.
- QPSK, DIFF_EN=0, SPS=8, continuous valid, beats tdata=0,1,3,2 (tuser=0, tlast on the 4th) →
  - I/Q = (+1447,+1447), (+1447,-1447), (-1447,-1447), (-1447,+1447), 8 clocks each
  - sym_strobe every 8 clocks; tready high only on cnt==7
  - returns to IDLE with no underrun
- BPSK, tuser=1, beats tdata=2'b10 then 2'b00 → I = -1447 then +1447; Q = 0 throughout; sym_is_bpsk=1.
- Starvation: two QPSK beats, then tvalid low for 20 clocks, tlast=0 →
  - iq_valid drops 1 clock after the 2nd symbol's cnt==7 edge
  - underrun=1 and stays set
  - clr_underrun pulse → 0
- DIFF_EN=1, QPSK beats 01,01,00 → encoded e = 01, 00, 00 → Q = -1447, +1447, +1447; I = +1447 throughout.
- Mid-symbol rst at cnt==3 → next cycle outputs idle and tready=1. A beat offered in the rst cycle is not accepted; the same beat offered after rst is accepted and mapped normally.
